decrypt_req_arbiter: RTL and testbench

//  Shares one decryption core between two requesters (e.g. host port, DMA port).

---
 rtl/decrypt_req_arbiter.sv | 125 ++++++++++++
 tb/tb_decrypt_req_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_req_arbiter.sv
// -----------------------------------------------------------------------------
// decrypt_req_arbiter
//
// Shares one decryption core between two requesters. Requests are granted
// round-robin, the winning key/e_data are registered onto the core inputs,
// the core result is captured CORE_LAT clocks later, and it is returned
// together with the ID of the requester that owns it. Only one transaction
// is in flight at a time.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; req_ready may be asserted for the grant winner
// WAIT  | core inputs driven, counting down CORE_LAT until core_data valid
// RESP  | rsp_valid high, result held until the consumer takes it
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   req_valid[1:0]            per-requester request valid
//   req_ready[1:0]            per-requester accept (one-hot, IDLE only)
//   req{0,1}_key/_e_data      per-requester key and encrypted data
//   core_key, core_e_data     registered drive into the decryption core
//   core_data                 decrypted result from the core
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_id          captured result and owning requester
//   busy                      high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module decrypt_req_arbiter #(
    parameter int N        = 8,
    parameter int CORE_LAT = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_key,
    input  logic [N-1:0] req0_e_data,
    input  logic [N-1:0] req1_key,
    input  logic [N-1:0] req1_e_data,
    output logic [N-1:0] core_key,
    output logic [N-1:0] core_e_data,
    input  logic [N-1:0] core_data,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_data,
    output logic         rsp_id,
    input  logic         rsp_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;
    logic [3:0] lat_cnt;
    logic       grant;
    logic       grant_vld;

    // Round-robin: on contention the requester that did not win last time
    // gets the grant; otherwise the single valid requester wins.
    always_comb begin
        grant_vld = (state == IDLE) && (req_valid != 2'b00);
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req_valid[1];
        end
        req_ready = 2'b00;
        // Gated with reset_n so no handshake is ever seen while in reset.
        if (reset_n && grant_vld) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            lat_cnt     <= 4'd0;
            core_key    <= '0;
            core_e_data <= '0;
            rsp_data    <= '0;
            rsp_id      <= 1'b0;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        core_key    <= grant ? req1_key    : req0_key;
                        core_e_data <= grant ? req1_e_data : req0_e_data;
                        rsp_id      <= grant;
                        last_grant  <= grant;
                        lat_cnt     <= 4'(CORE_LAT);
                        busy        <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        rsp_data  <= core_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_req_arbiter.sv
`timescale 1ns/1ps
module tb_decrypt_req_arbiter;

    localparam int N        = 8;
    localparam int CORE_LAT = 1;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req0_key, req0_e_data, req1_key, req1_e_data;
    logic [N-1:0] core_key, core_e_data, core_data;
    logic         rsp_valid, rsp_id, rsp_ready, busy;
    logic [N-1:0] rsp_data;

    always #5 clock = ~clock;

    // Stub core: combinational xor decrypt.
    assign core_data = core_e_data ^ core_key;

    decrypt_req_arbiter #(.N(N), .CORE_LAT(CORE_LAT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_key    (req0_key),
        .req0_e_data (req0_e_data),
        .req1_key    (req1_key),
        .req1_e_data (req1_e_data),
        .core_key    (core_key),
        .core_e_data (core_e_data),
        .core_data   (core_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic         id;
        logic [N-1:0] data;
    } rsp_t;

    typedef struct {
        logic [1:0]   valid;
        logic [N-1:0] k0, d0, k1, d1;
        logic [1:0]   exp_ready;
        logic [N-1:0] exp_rsp;
    } vec_t;

    rsp_t sb_q[$];
    logic model_last = 1'b1;
    int   ncyc       = 0;
    int   acc_cyc    = 0;
    logic prev_rv    = 1'b0;
    bit   mon_en     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        req_valid   = v.valid;
        req0_key    = v.k0;
        req0_e_data = v.d0;
        req1_key    = v.k1;
        req1_e_data = v.d1;
    endtask

    // Monitor / scoreboard: predicts grants from a round-robin model, pushes
    // the expected response at each accept, pops and compares at each take.
    always @(negedge clock) begin
        logic       eg;
        logic [1:0] eready;
        rsp_t       r;
        ncyc++;
        if (reset_n && mon_en) begin
            if (busy) begin
                chk("ready_while_busy", 32'(req_ready), 32'd0);
            end else if (req_valid != 2'b00) begin
                eg     = (req_valid == 2'b11) ? ~model_last : req_valid[1];
                eready = eg ? 2'b10 : 2'b01;
                chk("rr_grant", 32'(req_ready), 32'(eready));
                r.id   = eg;
                r.data = eg ? (req1_key ^ req1_e_data) : (req0_key ^ req0_e_data);
                sb_q.push_back(r);
                model_last = eg;
                acc_cyc    = ncyc;
            end
            if (rsp_valid && !prev_rv)
                chk("rsp_latency", 32'(ncyc - acc_cyc), 32'(CORE_LAT + 1));
            if (rsp_valid && rsp_ready) begin
                chk("ready_on_take", 32'(req_ready), 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    r = sb_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(r.id));
                    chk("rsp_data", 32'(rsp_data), 32'(r.data));
                end
            end
            prev_rv = rsp_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    vec_t    tbl[10];
    int      n;
    realtime prev_t;

    initial begin
        // contention, single-valid, and alternating round-robin patterns
        tbl[0] = '{2'b11, 8'h0F, 8'h02, 8'hAA, 8'h55, 2'b01, 8'h0D};
        tbl[1] = '{2'b11, 8'h0F, 8'h02, 8'hAA, 8'h55, 2'b10, 8'hFF};
        tbl[2] = '{2'b01, 8'h00, 8'h01, 8'h33, 8'h44, 2'b01, 8'h01};
        tbl[3] = '{2'b10, 8'h11, 8'h22, 8'h5A, 8'h0F, 2'b10, 8'h55};
        tbl[4] = '{2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b01, 8'h26};
        tbl[5] = '{2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b10, 8'h2E};
        tbl[6] = '{2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b01, 8'h26};
        tbl[7] = '{2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b10, 8'h2E};
        tbl[8] = '{2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b01, 8'h26};
        tbl[9] = '{2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 2'b10, 8'h2E};

        reset_n     = 1'b0;
        req_valid   = 2'b00;
        req0_key    = '0;
        req0_e_data = '0;
        req1_key    = '0;
        req1_e_data = '0;
        rsp_ready   = 1'b0;

        // Held in reset with random inputs: every output stays zero.
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            req_valid   = 2'($urandom_range(3, 0));
            req0_key    = 8'($urandom);
            req0_e_data = 8'($urandom);
            req1_key    = 8'($urandom);
            req1_e_data = 8'($urandom);
            rsp_ready   = 1'($urandom_range(1, 0));
            @(negedge clock);
            chk("reset_outputs",
                32'({req_ready, core_key, core_e_data, rsp_valid, rsp_data, rsp_id, busy}),
                32'd0);
        end

        @(posedge clock); #1;
        req_valid  = 2'b00;
        rsp_ready  = 1'b1;
        model_last = 1'b1;
        sb_q.delete();
        mon_en     = 1'b1;
        reset_n    = 1'b1;

        // Table-driven back-to-back transactions; the next entry is presented
        // right after each accept and waits while the arbiter is busy.
        @(posedge clock); #1;
        apply(tbl[0]);
        prev_t = 0;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            do begin @(negedge clock); n++; end while (req_ready == 2'b00 && n < 20);
            chk("tbl_ready", 32'(req_ready), 32'(tbl[i].exp_ready));
            if (i > 0) chk("tbl_spacing", 32'(int'(($realtime - prev_t) / 10.0)), 32'(CORE_LAT + 2));
            prev_t = $realtime;
            @(posedge clock); #1;
            if (i + 1 < 10) apply(tbl[i + 1]);
            else req_valid = 2'b00;
            n = 0;
            do begin @(negedge clock); n++; end while (!rsp_valid && n < 20);
            chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("tbl_rsp_data", 32'(rsp_data), 32'(tbl[i].exp_rsp));
        end

        // Response back-pressure: everything holds while rsp_ready is low.
        @(posedge clock); #1;
        rsp_ready   = 1'b0;
        req_valid   = 2'b01;
        req0_key    = 8'h3C;
        req0_e_data = 8'hA5;
        n = 0;
        do begin @(negedge clock); n++; end while (req_ready == 2'b00 && n < 20);
        chk("bp_accept", 32'(req_ready), 32'b01);
        @(posedge clock); #1;
        req_valid   = 2'b10;
        req1_key    = 8'h5A;
        req1_e_data = 8'h0F;
        n = 0;
        do begin @(negedge clock); n++; end while (!rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_state", 32'({rsp_valid, rsp_data, rsp_id, req_ready, busy}),
                32'({1'b1, 8'h99, 1'b0, 2'b00, 1'b1}));
            chk("bp_core_key", 32'({core_key, core_e_data}), 32'({8'h3C, 8'hA5}));
        end
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (req_ready == 2'b00 && n < 20);
        chk("bp_next_grant", 32'(req_ready), 32'b10);
        @(posedge clock); #1;
        req_valid = 2'b00;

        // Reset during WAIT: the in-flight transaction vanishes and the
        // round-robin pointer returns to favouring requester 0.
        n = 0;
        do begin @(negedge clock); n++; end while (busy && n < 20);
        @(posedge clock); #1;
        req_valid   = 2'b11;
        req0_key    = 8'h81;
        req0_e_data = 8'h18;
        req1_key    = 8'h42;
        req1_e_data = 8'h24;
        n = 0;
        do begin @(negedge clock); n++; end while (req_ready == 2'b00 && n < 20);
        chk("mid_pre_grant", 32'(req_ready), 32'b01);
        @(posedge clock); #1;
        req_valid = 2'b00;
        chk("mid_in_wait", 32'(busy), 32'd1);
        #1;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mid_reset_outputs",
            32'({req_ready, core_key, core_e_data, rsp_valid, rsp_data, rsp_id, busy}),
            32'd0);
        sb_q.delete();
        model_last = 1'b1;
        #1;
        reset_n = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (req_ready == 2'b00 && n < 20);
        chk("post_reset_grant", 32'(req_ready), 32'b01);
        @(posedge clock); #1;
        req_valid = 2'b00;

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin @(negedge clock); n++; end
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (5) @(negedge clock);
        chk("idle_end", 32'({rsp_valid, busy}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
